// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: funct codes, command record,
// FSM state encoding and the latency-class helper.
package alu_pkg;

  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef struct packed {
    logic [5:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK
  } state_t;

  // Multi-cycle functs get the long latency; everything else, known or not, is short.
  function automatic logic is_long_op(input logic [5:0] sel);
    return (sel == F_MULTU) || (sel == F_DIVU);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for driver commands; pointers carry one extra wrap bit
// so full and empty are told apart without a counter.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 102,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Self-checking ALU initiator: queues commands, drives the ALU with stable
// operands for the op latency, then compares the result and tallies it.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LAT_SHORT  = 1,
  parameter int unsigned LAT_LONG   = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [5:0]       cmd_sel,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [31:0]      cmd_expect,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [5:0]       alu_sel,
  input  logic [31:0]      alu_result,
  output logic             rsp_valid,
  output logic [31:0]      rsp_result,
  output logic             rsp_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  localparam int unsigned LAT_MAX = (LAT_LONG > LAT_SHORT) ? LAT_LONG : LAT_SHORT;
  localparam int unsigned WAIT_W  = $clog2(LAT_MAX) + 1;

  state_t            state;
  state_t            state_next;
  cmd_t              wr_cmd;
  cmd_t              rd_cmd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              load_wait;
  logic              do_check;
  logic [31:0]       expect_q;
  logic [WAIT_W-1:0] wait_cnt;

  assign wr_cmd    = {cmd_sel, cmd_a, cmd_b, cmd_expect};
  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state != ST_IDLE) | ~fifo_empty;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_cmd),
    .rd_data (rd_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_wait  = 1'b0;
    do_check   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        load_wait  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        do_check   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operands only move on a pop, so the ALU sees them frozen across WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= F_ADD;
      expect_q   <= '0;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_pass   <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      rsp_valid <= do_check;
      if (pop) begin
        alu_a    <= rd_cmd.a;
        alu_b    <= rd_cmd.b;
        alu_sel  <= rd_cmd.sel;
        expect_q <= rd_cmd.exp_res;
      end
      if (load_wait) begin
        wait_cnt <= is_long_op(alu_sel) ? WAIT_W'(LAT_LONG - 1) : WAIT_W'(LAT_SHORT - 1);
      end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (do_check) begin
        rsp_result <= alu_result;
        rsp_pass   <= (alu_result == expect_q);
        if (alu_result == expect_q) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU responder.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LAT_SHORT  = 1;
  localparam int unsigned LAT_LONG   = 32;
  localparam int unsigned CNT_W      = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [5:0]       cmd_sel = '0;
  logic [31:0]      cmd_a = '0;
  logic [31:0]      cmd_b = '0;
  logic [31:0]      cmd_expect = '0;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [5:0]       alu_sel;
  logic [31:0]      alu_result;
  logic             rsp_valid;
  logic [31:0]      rsp_result;
  logic             rsp_pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] rsp_res_q[$];
  logic        rsp_pass_q[$];
  int          rsp_cyc_q[$];

  alu_cmd_driver #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LAT_SHORT  (LAT_SHORT),
    .LAT_LONG   (LAT_LONG),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sel    (cmd_sel),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_expect (cmd_expect),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_pass   (rsp_pass),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_sel)
      F_SRL:   alu_result = alu_b >> alu_a[4:0];
      F_MULTU: alu_result = alu_a * alu_b;
      F_DIVU:  alu_result = (alu_b != 0) ? alu_a / alu_b : '1;
      F_ADD:   alu_result = alu_a + alu_b;
      F_SUB:   alu_result = alu_a - alu_b;
      F_AND:   alu_result = alu_a & alu_b;
      F_OR:    alu_result = alu_a | alu_b;
      F_SLT:   alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rsp_valid) begin
      rsp_res_q.push_back(rsp_result);
      rsp_pass_q.push_back(rsp_pass);
      rsp_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] res_at(input int i);
    if (i < rsp_res_q.size()) return rsp_res_q[i];
    return 'x;
  endfunction

  function automatic logic pass_at(input int i);
    if (i < rsp_pass_q.size()) return rsp_pass_q[i];
    return 1'bx;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < rsp_cyc_q.size()) return rsp_cyc_q[i];
    return -1000;
  endfunction

  task automatic push(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e);
    int n = 0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_sel    = sel;
    cmd_a      = a;
    cmd_b      = b;
    cmd_expect = e;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout cmd_ready got %b want 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_res_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rsp_res_q.size() < target) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout responses got %0d want %0d", rsp_res_q.size(), target);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Latency is counted in cycles with the pop cycle as cycle 0.
  task automatic measure(input logic [5:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, output int lat, output int unstable,
                         output logic [31:0] res);
    int base = rsp_res_q.size();
    int pop_cyc = -1000;
    int n = 0;
    push(sel, a, b, e);
    while (n < 20 && pop_cyc < 0) begin
      @(negedge clk);
      n++;
      if (alu_a === a && alu_b === b && alu_sel === sel) pop_cyc = cyc;
    end
    unstable = 0;
    n = 0;
    while (n < 100 && rsp_res_q.size() == base) begin
      @(negedge clk);
      n++;
      if (alu_a !== a || alu_b !== b || alu_sel !== sel) unstable++;
    end
    lat = cyc_at(base) - pop_cyc + 1;
    res = res_at(base);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (alu_sel !== F_ADD) begin errors++; $display("FAIL reset_alu_sel got %0d want %0d", alu_sel, F_ADD); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu_ab got %h/%h want 0/0", alu_a, alu_b); end
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_pass !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b/%h/%b want 0/0/0", rsp_valid, rsp_result, rsp_pass); end
    checks++; if (pass_cnt !== '0 || fail_cnt !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release ready/busy got %b/%b want 1/0", cmd_ready, busy); end
  endtask

  task automatic test_slt;
    int base = rsp_res_q.size();
    push(F_SLT, 32'hFFFF_FFFC, 32'd11, 32'd1);
    wait_rsp(base + 1, 30);
    checks++; if (res_at(base) !== 32'd1 || pass_at(base) !== 1'b1) begin errors++; $display("FAIL slt_neg result/pass got %h/%b want 1/1", res_at(base), pass_at(base)); end
    checks++; if (pass_cnt !== 2'd1 || fail_cnt !== 2'd0) begin errors++; $display("FAIL slt_neg counters got %0d/%0d want 1/0", pass_cnt, fail_cnt); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd1) begin errors++; $display("FAIL rsp_pulse valid/result got %b/%h want 0/1", rsp_valid, rsp_result); end
    push(F_SLT, 32'h8000_0000, 32'd1, 32'd1);
    wait_rsp(base + 2, 30);
    checks++; if (res_at(base + 1) !== 32'd1 || pass_at(base + 1) !== 1'b1) begin errors++; $display("FAIL slt_min result/pass got %h/%b want 1/1", res_at(base + 1), pass_at(base + 1)); end
    checks++; if (pass_cnt !== 2'd2) begin errors++; $display("FAIL slt_min pass_cnt got %0d want 2", pass_cnt); end
  endtask

  task automatic test_mismatch;
    int base;
    do_reset();
    base = rsp_res_q.size();
    push(F_SLT, 32'd13, 32'd11, 32'd1);
    wait_rsp(base + 1, 30);
    checks++; if (res_at(base) !== 32'd0 || pass_at(base) !== 1'b0) begin errors++; $display("FAIL mismatch result/pass got %h/%b want 0/0", res_at(base), pass_at(base)); end
    checks++; if (fail_cnt !== 2'd1 || pass_cnt !== 2'd0) begin errors++; $display("FAIL mismatch counters fail/pass got %0d/%0d want 1/0", fail_cnt, pass_cnt); end
  endtask

  task automatic test_fifo_full;
    int base;
    logic [31:0] exp_res [6] = '{32'd14, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0};
    logic [31:0] sa [5] = '{32'd1, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd7};
    logic [31:0] sb [5] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
    do_reset();
    base = rsp_res_q.size();
    push(F_DIVU, 32'd100, 32'd7, 32'd14);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) push(F_SLT, sa[i], sb[i], exp_res[i + 1]);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fifo_full ready/busy got %b/%b want 0/1", cmd_ready, busy); end
    push(F_SLT, sa[4], sb[4], exp_res[5]);
    checks++; if (rsp_res_q.size() - base !== 1) begin errors++; $display("FAIL fifo_fifth_accept responses got %0d want 1", rsp_res_q.size() - base); end
    wait_rsp(base + 6, 100);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (res_at(base + i) !== exp_res[i] || pass_at(base + i) !== 1'b1) begin
        errors++;
        $display("FAIL fifo_order[%0d] result/pass got %h/%b want %h/1", i, res_at(base + i), pass_at(base + i), exp_res[i]);
      end
    end
    checks++; if (pass_cnt !== 2'd3 || fail_cnt !== 2'd0) begin errors++; $display("FAIL fifo_counters pass/fail got %0d/%0d want 3/0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_latency;
    int lat;
    int unstable;
    logic [31:0] res;
    do_reset();
    measure(F_ADD, 32'd7, 32'd5, 32'd12, lat, unstable, res);
    checks++; if (lat !== int'(LAT_SHORT + 3)) begin errors++; $display("FAIL lat_add cycles got %0d want %0d", lat, LAT_SHORT + 3); end
    checks++; if (unstable !== 0 || res !== 32'd12) begin errors++; $display("FAIL lat_add unstable/result got %0d/%h want 0/c", unstable, res); end
    measure(6'd63, 32'd1, 32'd2, 32'd0, lat, unstable, res);
    checks++; if (lat !== int'(LAT_SHORT + 3)) begin errors++; $display("FAIL lat_unknown cycles got %0d want %0d", lat, LAT_SHORT + 3); end
    measure(F_MULTU, 32'd6, 32'd7, 32'd42, lat, unstable, res);
    checks++; if (lat !== int'(LAT_LONG + 3)) begin errors++; $display("FAIL lat_multu cycles got %0d want %0d", lat, LAT_LONG + 3); end
    checks++; if (unstable !== 0 || res !== 32'd42) begin errors++; $display("FAIL lat_multu unstable/result got %0d/%h want 0/2a", unstable, res); end
  endtask

  task automatic test_reset_mid;
    int base;
    push(F_DIVU, 32'd1000, 32'd10, 32'd100);
    push(F_ADD, 32'd1, 32'd1, 32'd2);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sel !== F_ADD) begin errors++; $display("FAIL midrst_alu got %h/%h/%0d want 0/0/32", alu_a, alu_b, alu_sel); end
    checks++; if (rsp_result !== 32'd0 || rsp_pass !== 1'b0 || pass_cnt !== '0 || fail_cnt !== '0) begin errors++; $display("FAIL midrst_rsp got %h/%b/%0d/%0d want 0/0/0/0", rsp_result, rsp_pass, pass_cnt, fail_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    base = rsp_res_q.size();
    repeat (45) @(negedge clk);
    checks++; if (rsp_res_q.size() !== base || busy !== 1'b0 || alu_sel !== F_ADD) begin errors++; $display("FAIL midrst_after responses/busy/sel got %0d/%b/%0d want 0/0/32", rsp_res_q.size() - base, busy, alu_sel); end
  endtask

  task automatic test_back_to_back;
    int base;
    do_reset();
    base = rsp_res_q.size();
    for (int i = 1; i <= 5; i++) push(F_ADD, 32'(i), 32'(2 * i), 32'(3 * i));
    wait_rsp(base + 5, 60);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_at(base + i) !== 32'(3 * (i + 1)) || pass_at(base + i) !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d] result/pass got %h/%b want %h/1", i, res_at(base + i), pass_at(base + i), 3 * (i + 1));
      end
    end
    checks++; if (cyc_at(base + 4) - cyc_at(base + 3) !== int'(LAT_SHORT + 3)) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", cyc_at(base + 4) - cyc_at(base + 3), LAT_SHORT + 3); end
    checks++; if (pass_cnt !== 2'd3 || fail_cnt !== 2'd0) begin errors++; $display("FAIL saturation pass/fail got %0d/%0d want 3/0", pass_cnt, fail_cnt); end
  endtask

  initial begin
    test_reset();
    test_slt();
    test_mismatch();
    test_fifo_full();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
